// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait states, timeout, illegal-opcode flagging and a retired-instruction counter.
module cpu_multicycle_ctrl #(
    parameter int OPCODE_W    = 3,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] cpu_opcode,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic                dmem_rd,
    output logic                dmem_wr,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic [1:0]          pc_src,
    output logic                reg_wr,
    output logic [1:0]          dest_reg,
    output logic [1:0]          mem_to_reg,
    output logic [ALUOP_W-1:0]  alu_opcode,
    output logic                alu_src,
    output logic                sign_or_zero,
    output logic                illegal_op,
    output logic                bus_err,
    output logic                instr_retired,
    output logic [CNT_W-1:0]    retired_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SLI  = 3'd1;
    localparam logic [2:0] OP_J    = 3'd2;
    localparam logic [2:0] OP_JAL  = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_ADDI = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [2:0]          op_r;
    logic [WAIT_W-1:0]   wait_r;
    logic [CNT_W-1:0]    retired_cnt_r;

    logic                opcode_legal_s;
    logic                timeout_s;
    logic                imem_req_s, dmem_rd_s, dmem_wr_s, ir_wr_s, pc_wr_s, reg_wr_s;
    logic [1:0]          pc_src_s, dest_reg_s, mem_to_reg_s;
    logic [1:0]          alu_op_s;
    logic                alu_src_s, sign_s;
    logic                illegal_s, bus_err_s, retire_s;

    // Packed {alu_op[1:0], alu_src, sign_or_zero} for each opcode that reaches EXEC.
    function automatic logic [3:0] alu_ctrl(input logic [2:0] op);
        logic [3:0] c;
        case (op)
            OP_SLI:               c = 4'b10_1_0;
            OP_LW, OP_SW, OP_ADDI: c = 4'b11_1_1;
            OP_BEQ:               c = 4'b01_0_1;
            default:              c = 4'b00_0_1;
        endcase
        return c;
    endfunction

    assign opcode_legal_s = (32'(cpu_opcode) < 32'd8);
    // Timeout fires on the last allowed wait cycle; a late mem_ready still wins.
    assign timeout_s = (MEM_TIMEOUT != 0) && !mem_ready &&
                       ((state_r == S_FETCH) || (state_r == S_MEM)) &&
                       (int'(wait_r) == MEM_TIMEOUT - 1);

    // Next-state and control decode from state, held opcode and handshake inputs.
    always_comb begin
        state_nxt_s  = state_r;
        imem_req_s   = 1'b0;
        dmem_rd_s    = 1'b0;
        dmem_wr_s    = 1'b0;
        ir_wr_s      = 1'b0;
        pc_wr_s      = 1'b0;
        pc_src_s     = 2'b00;
        reg_wr_s     = 1'b0;
        dest_reg_s   = 2'b00;
        mem_to_reg_s = 2'b00;
        alu_op_s     = 2'b00;
        alu_src_s    = 1'b0;
        sign_s       = 1'b1;
        illegal_s    = 1'b0;
        bus_err_s    = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_wr_s     = 1'b1;
                    pc_wr_s     = 1'b1;
                    state_nxt_s = S_DECODE;
                end else if (timeout_s) begin
                    bus_err_s = 1'b1;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!opcode_legal_s) begin
                    illegal_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end else if ((cpu_opcode[2:0] == OP_J) || (cpu_opcode[2:0] == OP_JAL)) begin
                    pc_wr_s     = 1'b1;
                    pc_src_s    = 2'b10;
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                    if (cpu_opcode[2:0] == OP_JAL) begin
                        reg_wr_s     = 1'b1;
                        dest_reg_s   = 2'b10;
                        mem_to_reg_s = 2'b10;
                    end else begin
                        reg_wr_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                {alu_op_s, alu_src_s, sign_s} = alu_ctrl(op_r);
                case (op_r)
                    OP_BEQ: begin
                        pc_wr_s     = alu_zero;
                        pc_src_s    = 2'b01;
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    OP_LW, OP_SW: state_nxt_s = S_MEM;
                    default:      state_nxt_s = S_WB;
                endcase
            end
            S_MEM: begin
                {alu_op_s, alu_src_s, sign_s} = alu_ctrl(op_r);
                dmem_rd_s = (op_r == OP_LW);
                dmem_wr_s = (op_r != OP_LW);
                if (mem_ready) begin
                    retire_s    = (op_r != OP_LW);
                    state_nxt_s = (op_r == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout_s) begin
                    bus_err_s   = 1'b1;
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_WB: begin
                {alu_op_s, alu_src_s, sign_s} = alu_ctrl(op_r);
                reg_wr_s     = 1'b1;
                retire_s     = 1'b1;
                dest_reg_s   = (op_r == OP_ADD) ? 2'b01 : 2'b00;
                mem_to_reg_s = (op_r == OP_LW)  ? 2'b01 : 2'b00;
                state_nxt_s  = S_FETCH;
            end
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // State, opcode capture, wait counter and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_FETCH;
            op_r          <= 3'd0;
            wait_r        <= '0;
            retired_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                op_r <= cpu_opcode[2:0];
            end else begin
                op_r <= op_r;
            end
            if ((MEM_TIMEOUT != 0) && !mem_ready && !timeout_s &&
                ((state_r == S_FETCH) || (state_r == S_MEM))) begin
                wait_r <= wait_r + WAIT_W'(1);
            end else begin
                wait_r <= '0;
            end
            if (retire_s) begin
                retired_cnt_r <= retired_cnt_r + CNT_W'(1);
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
        end
    end

    // Reset forces every control output to its idle value immediately.
    assign imem_req      = imem_req_s   & ~rst;
    assign dmem_rd       = dmem_rd_s    & ~rst;
    assign dmem_wr       = dmem_wr_s    & ~rst;
    assign ir_wr         = ir_wr_s      & ~rst;
    assign pc_wr         = pc_wr_s      & ~rst;
    assign pc_src        = rst ? 2'b00 : pc_src_s;
    assign reg_wr        = reg_wr_s     & ~rst;
    assign dest_reg      = rst ? 2'b00 : dest_reg_s;
    assign mem_to_reg    = rst ? 2'b00 : mem_to_reg_s;
    assign alu_opcode    = rst ? '0 : ALUOP_W'(alu_op_s);
    assign alu_src       = alu_src_s    & ~rst;
    assign sign_or_zero  = sign_s       | rst;
    assign illegal_op    = illegal_s    & ~rst;
    assign bus_err       = bus_err_s    & ~rst;
    assign instr_retired = retire_s     & ~rst;
    assign retired_cnt   = retired_cnt_r;

endmodule
